servo_step_sequencer: RTL and testbench
=======================================

Name: servo_step_sequencer

Overview:
- Upstream command stage for one tracking servo channel; sits between the APB decode and the tracking-servo command inputs (SET_PW_FORWARD / SET_PW_REVERSE / SET_PW_NEUTRAL).
- Accepts signed step requests, each a count of PWM periods to drive full-forward (positive) or full-reverse (negative), into a small FIFO.
- Replays each request as one command strobe per PWM period, then holds neutral for a settle interval before starting the next request.
- Strobes are issued at a fixed mid-period offset, so the servo latches each one well before its period boundary.

Parameters:
- PERIOD_CYCLES, 2000001, length of one servo PWM period in PCLK cycles. The servo period is PWM_PERIOD+1.
- CMD_OFFSET, 500000, period-counter value at which a command strobe is issued. Must be less than PERIOD_CYCLES.
- SETTLE_PERIODS, 2, neutral periods inserted after each request. Must be at least 1.
- FIFO_DEPTH, 4, number of request entries. Must be a power of 2.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous reset, active-high
- push  in  1  enqueue step_in (single-cycle strobe)
- step_in  in  16  signed step count, two's complement
- abort  in  1  flush FIFO and force neutral
- set_fwd  out  1  one-cycle strobe to SET_PW_FORWARD
- set_rev  out  1  one-cycle strobe to SET_PW_REVERSE
- set_neu  out  1  one-cycle strobe to SET_PW_NEUTRAL
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse when a request's settle interval completes
- fifo_full  out  1  FIFO count equals FIFO_DEPTH
- fifo_count  out  3  entries held (width = log2(FIFO_DEPTH)+1)
- overflow  out  1  sticky flag: a push was dropped
- remaining  out  16  unsigned steps left in the current request

Behaviour:
Decided interface:
- One clock; reset is synchronous and active-high.
- Ports are PCLK and PRESET.

Reset:
- While PRESET is high at a PCLK edge, all outputs go to 0: strobes, busy, done, fifo_full, fifo_count, overflow, remaining.
- Reset also clears the FIFO, sets the period counter to 0 and puts the FSM in IDLE.
- Reset mid-request drops the request and issues no strobe.

Period counter:
- pcnt counts 0..PERIOD_CYCLES-1, then wraps to 0. It free-runs in every state.
- slot = (pcnt == CMD_OFFSET). All strobes except abort are issued only in a slot cycle.

FIFO:
- A push is accepted iff fifo_full=0, including a cycle with a simultaneous pop (count unchanged).
- A push while full is dropped and sets overflow.
- overflow is cleared only by PRESET or abort.

FSM states: IDLE, RUN, SETTLE.
- IDLE:
  - If fifo_count>0: pop the head entry.
  - Next cycle: remaining = |step|, dir = sign; go to RUN.
  - |-32768| = 32768 is representable in the unsigned 16-bit remaining.
- RUN, at each slot:
  - remaining>0: pulse set_fwd (dir positive) or set_rev (dir negative), and decrement remaining.
  - remaining==0: pulse set_neu, load settle_cnt = SETTLE_PERIODS, go to SETTLE.
  - A step of 0 goes straight to a neutral strobe at the first slot.
- SETTLE, at each slot:
  - Decrement settle_cnt.
  - On the slot where it reaches 0: pulse done for one cycle and go to IDLE. No strobe is issued in SETTLE.
- Consecutive requests: the next pop happens the cycle after entering IDLE. Its first strobe is at the next slot, never in the same slot as done.

Strobe rules:
- At most one of set_fwd, set_rev, set_neu is high in any cycle.
- Strobes are exactly one cycle wide.

abort (highest priority after PRESET):
- Next cycle: set_neu pulses once, FIFO is emptied, remaining=0, overflow=0, FSM goes to IDLE, no done pulse.
- This strobe is not slot-aligned.
- abort coincident with push: the push is discarded.
- abort in IDLE with an empty FIFO still pulses set_neu.

Test Plan:
Bench parameters for all scenarios: PERIOD_CYCLES=20, CMD_OFFSET=5, SETTLE_PERIODS=2, FIFO_DEPTH=4.
1. Push +3 after reset -> set_fwd at three consecutive slots (pcnt=5 of periods 1..3), remaining 3→2→1→0; set_neu at the next slot; done at 2 slots later; busy low the following cycle.
2. Push -2, then push +1 while busy -> two set_rev strobes, set_neu, settle, done. Then one set_fwd starts at the slot after done, never in the same slot as done.
3. Push 0 -> a single set_neu at the first slot, then done 2 slots later; no fwd/rev strobe.
4. Five pushes while FIFO is full (one request popped and running) -> fifo_count saturates at 4, overflow=1, and the dropped value is never executed.
5. abort mid-RUN with remaining=5 and 2 entries queued -> set_neu the next cycle, fifo_count=0, overflow=0, busy=0, no done, no further strobes.
6. Push -32768, with PRESET asserted after 2 strobes -> remaining reads 32768 after load; on PRESET all outputs are 0 the next cycle and no strobe follows.

Source files
------------

// File: rtl/servo_step_sequencer.sv
// Step-request sequencer for one tracking servo channel: queues signed step counts and
// replays them as slot-aligned forward/reverse/neutral command strobes with a neutral settle.
module servo_step_sequencer #(
  parameter int unsigned PERIOD_CYCLES  = 2000001,
  parameter int unsigned CMD_OFFSET     = 500000,
  parameter int unsigned SETTLE_PERIODS = 2,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          push,
  input  logic [15:0]                   step_in,
  input  logic                          abort,
  output logic                          set_fwd,
  output logic                          set_rev,
  output logic                          set_neu,
  output logic                          busy,
  output logic                          done,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   remaining
);

  localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(SETTLE_PERIODS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic          slot_nxt;
  logic [SW-1:0] settle_cnt;
  logic          dir_neg;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   head;
  logic [15:0]   head_abs;
  logic          pop;
  logic          push_ok;

  // Strobes are registered, so decisions use the next counter value; a strobe is then
  // visible exactly in the cycle where pcnt == CMD_OFFSET.
  always_comb begin
    pcnt_nxt = (pcnt == PW'(PERIOD_CYCLES - 1)) ? '0 : pcnt + PW'(1);
    slot_nxt = (pcnt_nxt == PW'(CMD_OFFSET));
  end

  assign head      = mem[rd_ptr];
  assign head_abs  = head[15] ? (~head + 16'd1) : head;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign busy      = (state != IDLE);
  assign pop       = (state == IDLE) && (fifo_count != '0) && !abort;
  assign push_ok   = push && !fifo_full && !abort;

  always_ff @(posedge PCLK) begin
    if (push_ok && !PRESET) mem[wr_ptr] <= step_in;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      pcnt       <= '0;
      settle_cnt <= '0;
      dir_neg    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      remaining  <= '0;
      set_fwd    <= 1'b0;
      set_rev    <= 1'b0;
      set_neu    <= 1'b0;
      done       <= 1'b0;
    end else begin
      pcnt    <= pcnt_nxt;
      set_fwd <= 1'b0;
      set_rev <= 1'b0;
      set_neu <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        set_neu    <= 1'b1;
        state      <= IDLE;
        settle_cnt <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        overflow   <= 1'b0;
        remaining  <= '0;
      end else begin
        if (push && fifo_full) overflow <= 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      fifo_count <= fifo_count + CW'(1);
        else if (pop && !push_ok) fifo_count <= fifo_count - CW'(1);

        case (state)
          IDLE: begin
            if (pop) begin
              remaining <= head_abs;
              dir_neg   <= head[15];
              state     <= RUN;
            end
          end
          RUN: begin
            if (slot_nxt) begin
              if (remaining != '0) begin
                set_fwd   <= !dir_neg;
                set_rev   <= dir_neg;
                remaining <= remaining - 16'd1;
              end else begin
                set_neu    <= 1'b1;
                settle_cnt <= SW'(SETTLE_PERIODS);
                state      <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (slot_nxt) begin
              settle_cnt <= settle_cnt - SW'(1);
              if (settle_cnt == SW'(1)) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_step_sequencer.sv
// Bench for servo_step_sequencer: directed scenarios plus random traffic, every cycle
// compared against a request/event-queue reference model.
module tb_servo_step_sequencer;

  localparam int PER = 20;
  localparam int OFF = 5;
  localparam int SET = 2;
  localparam int DEP = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        push = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] step_in = '0;
  logic        set_fwd, set_rev, set_neu, busy, done, fifo_full, overflow;
  logic [2:0]  fifo_count;
  logic [15:0] remaining;

  servo_step_sequencer #(
    .PERIOD_CYCLES (PER),
    .CMD_OFFSET    (OFF),
    .SETTLE_PERIODS(SET),
    .FIFO_DEPTH    (DEP)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .push      (push),
    .step_in   (step_in),
    .abort     (abort),
    .set_fwd   (set_fwd),
    .set_rev   (set_rev),
    .set_neu   (set_neu),
    .busy      (busy),
    .done      (done),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .remaining (remaining)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued requests plus the current request expanded into one event
  // per slot (F/R strobe, N neutral, '.' quiet settle slot, D done).
  int  mq[$];
  byte job[$];
  bit  m_busy, m_ovf;
  int  m_pcnt;
  bit  e_fwd, e_rev, e_neu, e_done;

  function automatic int m_rem();
    if (job.size() > SET + 1) return job.size() - (SET + 1);
    return 0;
  endfunction

  task automatic model_step();
    int pre;
    int v;
    int n;
    byte e;
    e_fwd = 0; e_rev = 0; e_neu = 0; e_done = 0;
    if (PRESET) begin
      mq.delete(); job.delete(); m_busy = 0; m_ovf = 0; m_pcnt = 0;
      return;
    end
    m_pcnt = (m_pcnt + 1) % PER;
    if (abort) begin
      mq.delete(); job.delete(); m_busy = 0; m_ovf = 0; e_neu = 1;
      return;
    end
    pre = mq.size();
    if (!m_busy && pre > 0) begin
      v = mq.pop_front();
      n = (v < 0) ? -v : v;
      job.delete();
      for (int i = 0; i < n; i++) job.push_back((v < 0) ? "R" : "F");
      job.push_back("N");
      for (int i = 0; i < SET - 1; i++) job.push_back(".");
      job.push_back("D");
      m_busy = 1;
    end else if (m_busy && m_pcnt == OFF) begin
      e = job.pop_front();
      case (e)
        "F": e_fwd = 1;
        "R": e_rev = 1;
        "N": e_neu = 1;
        "D": begin e_done = 1; m_busy = 0; end
        default: ;
      endcase
    end
    if (push) begin
      if (pre < DEP) mq.push_back(int'($signed(step_in)));
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check("set_fwd", int'(set_fwd), int'(e_fwd));
    check("set_rev", int'(set_rev), int'(e_rev));
    check("set_neu", int'(set_neu), int'(e_neu));
    check("done", int'(done), int'(e_done));
    check("busy", int'(busy), int'(m_busy));
    check("fifo_count", int'(fifo_count), mq.size());
    check("fifo_full", int'(fifo_full), int'(mq.size() == DEP));
    check("overflow", int'(overflow), int'(m_ovf));
    check("remaining", int'(remaining), m_rem());
    check("onehot", int'($countones({set_fwd, set_rev, set_neu}) <= 1), 1);
  endtask

  task automatic tick();
    @(posedge PCLK);
    model_step();
    @(negedge PCLK);
    compare_all();
    push  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_push(input int v);
    push    = 1'b1;
    step_in = 16'(v);
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while ((busy || fifo_count != 0) && k < bound) begin
      tick();
      k++;
    end
    check(tag, int'(k < bound), 1);
  endtask

  initial begin
    int k;
    int nrev;
    int r;

    // Reset
    PRESET = 1'b1;
    run(2);
    check("rst_busy", int'(busy), 0);
    check("rst_remaining", int'(remaining), 0);
    PRESET = 1'b0;
    run(3);

    // 1: +3
    do_push(3);
    tick();
    check("s1_load", int'(remaining), 3);
    wait_idle("s1_timeout", 300);
    run(5);

    // 2: -2 then +1 queued behind it
    do_push(-2);
    run(3);
    do_push(1);
    wait_idle("s2_timeout", 400);
    run(5);

    // 3: zero step
    do_push(0);
    wait_idle("s3_timeout", 200);

    // 4: overflow while one request runs and four are queued
    do_push(1);
    tick();
    for (int i = 0; i < 4; i++) do_push(1);
    for (int i = 0; i < 5; i++) do_push(9);
    check("s4_count", int'(fifo_count), 4);
    check("s4_overflow", int'(overflow), 1);
    wait_idle("s4_timeout", 2000);

    // 5: abort mid-run with entries queued
    do_push(7);
    k = 0;
    while (remaining != 16'd5 && k < 400) begin tick(); k++; end
    check("s5_reach5", int'(k < 400), 1);
    do_push(2);
    do_push(3);
    abort = 1'b1;
    tick();
    check("s5_neu", int'(set_neu), 1);
    check("s5_count", int'(fifo_count), 0);
    check("s5_busy", int'(busy), 0);
    check("s5_overflow", int'(overflow), 0);
    run(100);

    // 6: most negative step, reset after two strobes
    do_push(-32768);
    tick();
    check("s6_load", int'(remaining), 32768);
    nrev = 0;
    k = 0;
    while (nrev < 2 && k < 200) begin
      tick();
      if (set_rev) nrev++;
      k++;
    end
    check("s6_two_rev", nrev, 2);
    PRESET = 1'b1;
    tick();
    check("s6_rst_remaining", int'(remaining), 0);
    check("s6_rst_busy", int'(busy), 0);
    PRESET = 1'b0;
    run(60);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      PRESET = (r < 2);
      abort  = (r >= 2 && r < 5);
      if ($urandom_range(0, 24) == 0) begin
        push    = 1'b1;
        step_in = 16'(int'($urandom_range(0, 8)) - 4);
      end
      tick();
    end
    PRESET = 1'b0;
    abort  = 1'b1;
    tick();
    wait_idle("final_idle", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
